// File: rtl/battleship_turn_ctrl.sv
// battleship_turn_ctrl: Battleship turn sequencer for NUM_PLAYERS players (setup, aim/fire, check, error, win)
// Ports:
//   clk, clr_n           clock, asynchronous active-low reset
//   start                leave setup / restart after a win (level)
//   fire, ok, alive      per-player fire button, input-checker result, still-alive flag
//   ld_ships, ld_shot    per-player ship / attack register load enables
//   setup, disp_mode     setup phase flag, per-player 2-bit display code (0 off, 1 active, 2 waiting, 3 error)
//   turn, game_over      current attacker, win reached
//   winner, timeout      winning player, one-cycle forfeit pulse
// Optional feature: define BATTLESHIP_TURN_TIMEOUT_EN to forfeit a turn after TIMEOUT_CYCLES aim cycles.
module battleship_turn_ctrl #(
    parameter int NUM_PLAYERS    = 2,
    parameter int ERR_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int PW            = $clog2(NUM_PLAYERS)
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     start,
    input  logic [NUM_PLAYERS-1:0]   fire,
    input  logic [NUM_PLAYERS-1:0]   ok,
    input  logic [NUM_PLAYERS-1:0]   alive,
    output logic [NUM_PLAYERS-1:0]   ld_ships,
    output logic [NUM_PLAYERS-1:0]   ld_shot,
    output logic                     setup,
    output logic [2*NUM_PLAYERS-1:0] disp_mode,
    output logic [PW-1:0]            turn,
    output logic                     game_over,
    output logic [PW-1:0]            winner,
    output logic                     timeout
);
    localparam int CW = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
    localparam logic [NUM_PLAYERS-1:0] ONE = NUM_PLAYERS'(1);

    typedef enum logic [2:0] {SETUP, AIM, CHECK, ERROR, NEXT, WIN} state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          turn_q, turn_d, winner_q, winner_d;
    logic [CW-1:0]          err_q, err_d;
    logic [NUM_PLAYERS-1:0] fire_q, fire_edge;
    logic [PW-1:0]          target, lowest, p, q;
    logic                   t_found, l_found;
    logic [1:0]             code;
    logic [2*NUM_PLAYERS-1:0] disp;

`ifdef BATTLESHIP_TURN_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] aim_q, aim_d;
    logic          timeout_q, timeout_d;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign fire_edge = fire & ~fire_q;

    // target: first alive player after turn (wrapping); lowest: lowest alive index
    always_comb begin
        target  = turn_q;
        t_found = 1'b0;
        p       = turn_q;
        for (int k = 1; k < NUM_PLAYERS; k++) begin
            p = (p == PW'(NUM_PLAYERS - 1)) ? '0 : p + 1'b1;
            if (!t_found && alive[p]) begin
                target  = p;
                t_found = 1'b1;
            end
        end
        lowest  = turn_q;
        l_found = 1'b0;
        q       = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            if (!l_found && alive[q]) begin
                lowest  = q;
                l_found = 1'b1;
            end
            q = q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        turn_d   = turn_q;
        winner_d = winner_q;
        err_d    = '0;
`ifdef BATTLESHIP_TURN_TIMEOUT_EN
        aim_d     = '0;
        timeout_d = 1'b0;
`endif
        case (state_q)
            SETUP: if (start) begin
                state_d = AIM;
                turn_d  = '0;
            end
            AIM: begin
                if (fire_edge[turn_q]) state_d = CHECK;
`ifdef BATTLESHIP_TURN_TIMEOUT_EN
                else if (aim_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = NEXT;
                    timeout_d = 1'b1;
                end else aim_d = aim_q + 1'b1;
`endif
            end
            CHECK: state_d = ok[turn_q] ? NEXT : ERROR;
            ERROR: if (err_q == CW'(ERR_CYCLES - 1)) state_d = AIM;
                   else err_d = err_q + 1'b1;
            NEXT: if ($countones(alive) <= 1) begin
                state_d  = WIN;
                winner_d = lowest;
            end else begin
                state_d = AIM;
                turn_d  = target;
            end
            WIN: if (start) begin
                state_d  = SETUP;
                turn_d   = '0;
                winner_d = '0;
            end
            default: state_d = SETUP;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= SETUP;
            turn_q   <= '0;
            winner_q <= '0;
            err_q    <= '0;
            fire_q   <= '0;
`ifdef BATTLESHIP_TURN_TIMEOUT_EN
            aim_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            turn_q   <= turn_d;
            winner_q <= winner_d;
            err_q    <= err_d;
            fire_q   <= fire;
`ifdef BATTLESHIP_TURN_TIMEOUT_EN
            aim_q     <= aim_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Display codes are shifted in from the top so player 0 ends in bits [1:0]
    always_comb begin
        disp = '0;
        code = 2'd0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            code = (state_q == WIN)   ? ((PW'(k) == winner_q) ? 2'd1 : 2'd0) :
                   (state_q == SETUP) ? 2'd0 :
                   (PW'(k) == turn_q) ? ((state_q == ERROR) ? 2'd3 : 2'd1) :
                   alive[k]           ? 2'd2 : 2'd0;
            disp = {code, disp[2*NUM_PLAYERS-1:2]};
        end
    end

    assign disp_mode = disp;
    assign setup     = (state_q == SETUP);
    assign ld_ships  = (state_q == SETUP) ? '1 : (state_q == CHECK) ? ONE << target : '0;
    assign ld_shot   = (state_q == CHECK) ? ONE << turn_q : '0;
    assign turn      = turn_q;
    assign winner    = winner_q;
    assign game_over = (state_q == WIN);
endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// tb_battleship_turn_ctrl: directed self-checking bench for a 3-player battleship_turn_ctrl
module tb_battleship_turn_ctrl;
    logic       clk = 1'b0;
    logic       clr_n, start;
    logic [2:0] fire, ok, alive;
    logic [2:0] ld_ships, ld_shot;
    logic       setup, game_over, timeout;
    logic [5:0] disp_mode;
    logic [1:0] turn, winner;
    int         n_cmp = 0;
    int         n_err = 0;

    localparam logic [5:0] A0  = 6'b10_10_01;
    localparam logic [5:0] A1  = 6'b10_01_10;
    localparam logic [5:0] A2  = 6'b01_10_10;
    localparam logic [5:0] S0  = 6'b10_00_01;
    localparam logic [5:0] S2  = 6'b01_00_10;
    localparam logic [5:0] E2  = 6'b11_00_10;
    localparam logic [5:0] W2  = 6'b01_00_00;

    battleship_turn_ctrl #(.NUM_PLAYERS(3), .ERR_CYCLES(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .fire(fire), .ok(ok), .alive(alive),
        .ld_ships(ld_ships), .ld_shot(ld_shot), .setup(setup), .disp_mode(disp_mode),
        .turn(turn), .game_over(game_over), .winner(winner), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] e_ships, input logic [2:0] e_shot,
                       input logic e_setup, input logic [5:0] e_disp, input logic [1:0] e_turn,
                       input logic e_go);
        chk1({tag, ".ld_ships"}, 32'(ld_ships), 32'(e_ships));
        chk1({tag, ".ld_shot"}, 32'(ld_shot), 32'(e_shot));
        chk1({tag, ".setup"}, 32'(setup), 32'(e_setup));
        chk1({tag, ".disp_mode"}, 32'(disp_mode), 32'(e_disp));
        chk1({tag, ".turn"}, 32'(turn), 32'(e_turn));
        chk1({tag, ".game_over"}, 32'(game_over), 32'(e_go));
        chk1({tag, ".timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        clr_n = 1'b0; start = 1'b0; fire = 3'b000; ok = 3'b000; alive = 3'b111;
        #2;
        chk("reset", 3'b111, 3'b000, 1'b1, 6'd0, 2'd0, 1'b0);
        chk1("reset.winner", 32'(winner), 32'd0);
        #1 clr_n = 1'b1;
        step();
        chk("setup_hold", 3'b111, 3'b000, 1'b1, 6'd0, 2'd0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("aim0", 3'b000, 3'b000, 1'b0, A0, 2'd0, 1'b0);
        fire = 3'b010;
        step();
        fire = 3'b000;
        chk("other_fire", 3'b000, 3'b000, 1'b0, A0, 2'd0, 1'b0);
        fire = 3'b001; ok = 3'b001;
        step();
        chk("check0", 3'b010, 3'b001, 1'b0, A0, 2'd0, 1'b0);
        step();
        chk("next0", 3'b000, 3'b000, 1'b0, A0, 2'd0, 1'b0);
        fire = 3'b000;
        step();
        chk("aim1", 3'b000, 3'b000, 1'b0, A1, 2'd1, 1'b0);
        fire = 3'b010; ok = 3'b010;
        step();
        fire = 3'b000;
        chk("check1", 3'b100, 3'b010, 1'b0, A1, 2'd1, 1'b0);
        step();
        step();
        chk("aim2", 3'b000, 3'b000, 1'b0, A2, 2'd2, 1'b0);
        fire = 3'b100; ok = 3'b100;
        step();
        fire = 3'b000;
        chk("check2_wrap", 3'b001, 3'b100, 1'b0, A2, 2'd2, 1'b0);
        step();
        step();
        chk("aim0_wrap", 3'b000, 3'b000, 1'b0, A0, 2'd0, 1'b0);
        alive = 3'b101; fire = 3'b001; ok = 3'b001;
        step();
        fire = 3'b000;
        chk("skip_check", 3'b100, 3'b001, 1'b0, S0, 2'd0, 1'b0);
        step();
        step();
        chk("skip_aim", 3'b000, 3'b000, 1'b0, S2, 2'd2, 1'b0);
        ok = 3'b000; fire = 3'b100;
        step();
        chk("bad_check", 3'b001, 3'b100, 1'b0, S2, 2'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("error_hold", 3'b000, 3'b000, 1'b0, E2, 2'd2, 1'b0);
        end
        step();
        chk("error_exit", 3'b000, 3'b000, 1'b0, S2, 2'd2, 1'b0);
        step();
        chk("held_no_retrig", 3'b000, 3'b000, 1'b0, S2, 2'd2, 1'b0);
        fire = 3'b000;
        step();
        chk("released", 3'b000, 3'b000, 1'b0, S2, 2'd2, 1'b0);
        fire = 3'b100; ok = 3'b100;
        step();
        chk("refire", 3'b001, 3'b100, 1'b0, S2, 2'd2, 1'b0);
        alive = 3'b100; fire = 3'b000;
        step();
        chk("last_next", 3'b000, 3'b000, 1'b0, W2, 2'd2, 1'b0);
        step();
        chk("win", 3'b000, 3'b000, 1'b0, W2, 2'd2, 1'b1);
        chk1("win.winner", 32'(winner), 32'd2);
        step();
        chk("win_hold", 3'b000, 3'b000, 1'b0, W2, 2'd2, 1'b1);
        start = 1'b1;
        step();
        chk("restart", 3'b111, 3'b000, 1'b1, 6'd0, 2'd0, 1'b0);
        chk1("restart.winner", 32'(winner), 32'd0);
        alive = 3'b111;
        step();
        chk("aim_again", 3'b000, 3'b000, 1'b0, A0, 2'd0, 1'b0);
        step();
        chk("start_ignored", 3'b000, 3'b000, 1'b0, A0, 2'd0, 1'b0);
        start = 1'b0;
        clr_n = 1'b0;
        #1;
        chk("mid_reset", 3'b111, 3'b000, 1'b1, 6'd0, 2'd0, 1'b0);
        #1 clr_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("to_aim", 3'b000, 3'b000, 1'b0, A0, 2'd0, 1'b0);
`ifdef BATTLESHIP_TURN_TIMEOUT_EN
        repeat (7) step();
        chk("pre_timeout", 3'b000, 3'b000, 1'b0, A0, 2'd0, 1'b0);
        step();
        chk1("timeout.pulse", 32'(timeout), 32'd1);
        chk1("timeout.ld_ships", 32'(ld_ships), 32'd0);
        chk1("timeout.ld_shot", 32'(ld_shot), 32'd0);
        chk1("timeout.turn", 32'(turn), 32'd0);
        step();
        chk("after_timeout", 3'b000, 3'b000, 1'b0, A1, 2'd1, 1'b0);
`else
        repeat (20) step();
        chk("no_timeout", 3'b000, 3'b000, 1'b0, A0, 2'd0, 1'b0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
